// File: rtl/mux_dff_arbiter_pkg.sv
// ============================================================================
// mux_dff_arbiter_pkg : shared state encoding and hold-counter sizing
// Rev 1.0
// ============================================================================
`default_nettype none

package mux_dff_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  // The counter must represent 0..MAX_HOLD-1, so never narrower than 1 bit.
  function automatic int hold_cnt_width(input int max_hold);
    return (max_hold < 2) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_dff_arbiter_mux_dff.sv
// ============================================================================
// mux_dff_arbiter_mux_dff : WIDTH-bit 2:1 mux into an enabled, sync-reset flop
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_dff_arbiter_mux_dff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_valid_o
);

  logic [WIDTH-1:0] q_q;
  logic             valid_q;
  logic [WIDTH-1:0] w_mux;

  assign w_mux = sel_i ? d1_i : d0_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en_i;
      if (en_i) begin
        q_q <= w_mux;
      end
    end
  end

  assign q_o       = q_q;
  assign q_valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/mux_dff_arbiter.sv
// ============================================================================
// mux_dff_arbiter : round-robin owner of a shared muxed data register
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_dff_arbiter
  import mux_dff_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  localparam int HW = hold_cnt_width(MAX_HOLD);
  localparam logic [HW-1:0] c_hold_last = HW'(MAX_HOLD - 1);

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q,  hold_d;
  logic            last_q,  last_d;
  logic            sel_q,   sel_d;
  logic            w_cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  assign w_cap = ((state_q == G0) && req0) || ((state_q == G1) && req1);

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    last_d  = last_q;
    sel_d   = sel_q;

    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_q ? G0 : G1;
        else if (req0)     state_d = G0;
        else if (req1)     state_d = G1;
      end
      G0: begin
        if (!req0) begin
          state_d = req1 ? G1 : IDLE;
        end else if ((hold_q == c_hold_last) && req1) begin
          state_d = G1;
        end else begin
          // Saturate when nobody is waiting so an uncontested owner keeps the bus.
          hold_d = (hold_q == c_hold_last) ? hold_q : hold_q + 1'b1;
        end
      end
      G1: begin
        if (!req1) begin
          state_d = req0 ? G0 : IDLE;
        end else if ((hold_q == c_hold_last) && req0) begin
          state_d = G0;
        end else begin
          hold_d = (hold_q == c_hold_last) ? hold_q : hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == G0) begin
      last_d = 1'b0;
      sel_d  = 1'b0;
    end else if (state_d == G1) begin
      last_d = 1'b1;
      sel_d  = 1'b1;
    end
  end

  mux_dff_arbiter_mux_dff #(
    .WIDTH (WIDTH)
  ) u_mux_dff (
    .clk       (clk),
    .rst       (rst),
    .sel_i     (sel_q),
    .en_i      (w_cap),
    .d0_i      (d0),
    .d1_i      (d1),
    .q_o       (q),
    .q_valid_o (q_valid)
  );

  assign gnt0 = (state_q == G0);
  assign gnt1 = (state_q == G1);
  assign sel  = sel_q;

endmodule

`default_nettype wire

// File: doc/mux_dff_arbiter.md
# mux_dff_arbiter

Round-robin controller that shares a single WIDTH-bit muxed data register (2:1 select feeding a synchronously reset flop) between two requesters. It owns the mux select and capture enable, grants one requester at a time with a req/gnt handshake, and caps grant tenure at MAX_HOLD captures whenever the other side is waiting. It sits between the two producer ports and the downstream consumer of q/q_valid.

## Interface
- WIDTH, 8: data width of d0, d1, q.
- MAX_HOLD, 4: maximum consecutive captures per grant while the other requester waits; legal range ≥1.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 wants the register; held high for the whole transaction.
- req1  in  1  requester 1, same rules.
- d0  in  WIDTH  requester 0 data, sampled on each capture edge while gnt0 is high.
- d1  in  WIDTH  requester 1 data.
- gnt0  out  1  registered grant to requester 0.
- gnt1  out  1  registered grant to requester 1; never high together with gnt0.
- sel  out  1  registered mux select: 0 selects d0, 1 selects d1. Equals gnt1 when granted; otherwise holds its last value.
- q  out  WIDTH  register output.
- q_valid  out  1  high for one cycle after each capture.

## Operation
- States: IDLE, G0, G1. gnt0 = (state==G0), gnt1 = (state==G1).
- Capture condition (cap): (G0 & req0) or (G1 & req1). On cap, q <= selected d and q_valid <= 1. Otherwise q holds and q_valid <= 0.
- hold_cnt counts captures in the current grant. It resets to 0 on every grant change and in IDLE. Width is $clog2(MAX_HOLD+1).
- `last` records the most recently granted requester.
- IDLE: req0 only → G0. req1 only → G1. Both → the requester ≠ last. Neither → stay.
- G0:
  - req0 low (release): req1 → G1, else → IDLE. No capture on this edge.
  - req0 high and hold_cnt==MAX_HOLD-1 and req1 high: capture, then → G1 (forced switch, no idle bubble).
  - Otherwise: capture, stay, hold_cnt++. hold_cnt saturates at MAX_HOLD-1 while no competitor is present.
- G1: symmetric to G0.
- `last` updates on entry to G0/G1.

## Timing
- Reset values (after the rst edge): state=IDLE, gnt0=gnt1=0, sel=0, q=0, q_valid=0, hold_cnt=0, last=1, so req0 wins the first tie.
- rst has priority over every other event, including mid-grant. The grant drops and q clears on the same edge. An in-flight capture is discarded.
- Request-to-grant latency is 1 cycle: req sampled high at edge N gives gnt high after edge N.
- First capture happens at edge N+1 if req is still high; q/q_valid are visible after that edge. Grant-to-data latency is 1 cycle.
- Handover: after the last capture for requester A, gnt_A falls and gnt_B rises on the same edge. B's first capture is on the next edge. The bus is never idle for a cycle when B is waiting.
- Release edge: gnt drops one edge after req falls. Data presented on the release cycle is ignored.
- Simultaneous req0/req1 rise from IDLE is resolved by `last` only.
- MAX_HOLD=1 gives strict alternation under continuous contention.

## Structure
- Shared package holds the state enum (IDLE, G0, G1) and the hold-counter width function.
- One natural sub-module: mux_dff (WIDTH-bit 2:1 mux into a synchronously reset register with enable). The arbiter drives its sel/en.
- The FSM, counter, and `last` pointer live in the top module.

## Test plan
- Reset: drive rst=1 with req0=req1=1, d0=d1=8'hFF for one edge → q=0, q_valid=0, gnt0=gnt1=0. Release rst → gnt0=1 one edge later (last=1 at reset).
- Single requester: req0 high for 6 edges, d0=8'h11,8'h22,... → gnt0 after edge 1. q_valid high from edge 2, with q following d0 one cycle late. Drop req0 → gnt0=0 on the next edge, state IDLE.
- Contention, MAX_HOLD=4: req0 and req1 held high, d0=8'hA0+i, d1=8'hB0+i → exactly 4 captures from d0, then 4 from d1, alternating. No cycle with q_valid=0 after the first capture. gnt0 and gnt1 are never both high.
- Early release: in G0 with req1 waiting, drop req0 after 2 captures → gnt1 on the next edge. hold_cnt restarts; d1's first capture lands one edge later.
- Tie after idle: last grant was requester 1; assert req0 and req1 on the same edge from IDLE → gnt0=1. Repeat with last=0 → gnt1=1.
- Mid-grant reset: in G1 with hold_cnt=2, assert rst for one edge → all outputs at reset values. With req1 still high, gnt1 returns one edge after rst falls; req0 wins if both are high.
